rib_arbiter: RTL and testbench

//  Round-robin bus arbiter for the RIB interconnect; shares the single slave-side datapath between
//  the core data port (m0), core fetch port (m1), JTAG (m2) and UART-debug (m3) masters.

---
 rtl/tinyriscv_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/rib_arbiter.sv | 126 ++++++++++++
 tb/tb_rib_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared RIB interconnect constants and types for the bus arbiter.
package tinyriscv_pkg;

    localparam int RIB_MASTERS  = 4;
    localparam int RIB_MAX_HOLD = 16;
    localparam int RIB_IDX_W    = (RIB_MASTERS > 1) ? $clog2(RIB_MASTERS) : 1;

    // Bit i set: master i is a core port and is stalled through hold_flag_o.
    localparam logic [RIB_MASTERS-1:0] RIB_CORE_MASK = 4'b0011;

    typedef logic [RIB_IDX_W-1:0] rib_midx_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } rib_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping NUM-1 -> 0.
module rr_pick
#(
    parameter int NUM   = 4,
    parameter int IDX_W = 2
)
(
    input  logic [NUM-1:0]   req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan offsets from farthest to nearest so the nearest candidate is written last and wins.
    always_comb begin
        int c;
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int k = NUM - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % NUM;
            if (req_i[IDX_W'(c)]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin RIB bus arbiter with registered one-hot grant, bounded tenure and core stall flag.
// Handshake: a master owns the bus from the edge its gnt_o bit rises until the edge it falls;
// it keeps ownership while its req_i stays high, unless another master waits and tenure expires.
module rib_arbiter
    import tinyriscv_pkg::*;
#(
    parameter int                     NUM_MASTERS = RIB_MASTERS,
    parameter int                     MAX_HOLD    = RIB_MAX_HOLD,
    parameter logic [NUM_MASTERS-1:0] CORE_MASK   = RIB_CORE_MASK,
    localparam int                    IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
)
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   gnt_valid_o,
    output logic [IDX_W-1:0]       gnt_idx_o,
    output logic                   hold_flag_o,
    output logic                   preempt_o,
    output rib_arb_state_e         dbg_state_o
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    rib_arb_state_e          r_state;
    logic [NUM_MASTERS-1:0]  r_gnt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic                    r_preempt;

    logic [NUM_MASTERS-1:0]  w_pick_req;
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [NUM_MASTERS-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]        w_next_ptr;
    logic                    w_owner_req;
    logic                    w_hold_exp;

    // While owned, the current owner is masked so it cannot win its own handover.
    always_comb begin
        w_pick_req    = (r_state == ARB_OWNED) ? (req_i & ~r_gnt) : req_i;
        w_pick_onehot = NUM_MASTERS'(1) << w_pick_idx;
        w_next_ptr    = (w_pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_pick_idx + 1'b1;
        w_owner_req   = req_i[r_idx];
        w_hold_exp    = (r_hold_cnt >= HOLD_W'(MAX_HOLD - 1));
    end

    rr_pick #(
        .NUM   (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (w_pick_req),
        .ptr_i   (r_rr_ptr),
        .found_o (w_found),
        .idx_o   (w_pick_idx)
    );

    // Arbitration FSM: grant, tenure counter, round-robin pointer and preempt pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_idx      <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_found) begin
                        r_state  <= ARB_OWNED;
                        r_gnt    <= w_pick_onehot;
                        r_idx    <= w_pick_idx;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                ARB_OWNED: begin
                    if (!w_owner_req) begin
                        // Release wins over expiry, so no preempt pulse here.
                        r_hold_cnt <= '0;
                        if (w_found) begin
                            r_gnt    <= w_pick_onehot;
                            r_idx    <= w_pick_idx;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_state <= ARB_IDLE;
                            r_gnt   <= '0;
                            r_idx   <= '0;
                        end
                    end else if (w_hold_exp && w_found) begin
                        // Greater-or-equal also catches a waiter that arrives after saturation.
                        r_gnt      <= w_pick_onehot;
                        r_idx      <= w_pick_idx;
                        r_rr_ptr   <= w_next_ptr;
                        r_hold_cnt <= '0;
                        r_preempt  <= 1'b1;
                    end else if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_gnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Stall the core while a non-core master owns the bus or a core request waits.
    always_comb begin
        hold_flag_o = rst_ni &
                      (((|r_gnt) & ~CORE_MASK[r_idx]) | (|(req_i & CORE_MASK & ~r_gnt)));
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = |r_gnt;
    assign gnt_idx_o   = r_idx;
    assign preempt_o   = r_preempt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter with MAX_HOLD=4 and four masters (m0,m1 core).
module tb_rib_arbiter;
    import tinyriscv_pkg::*;

    logic           clk_i;
    logic           rst_ni;
    logic [3:0]     req_i;
    logic [3:0]     gnt_o;
    logic           gnt_valid_o;
    logic [1:0]     gnt_idx_o;
    logic           hold_flag_o;
    logic           preempt_o;
    rib_arb_state_e dbg_state_o;

    int checks;
    int errors;

    rib_arbiter #(
        .NUM_MASTERS (4),
        .MAX_HOLD    (4),
        .CORE_MASK   (4'b0011)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .hold_flag_o (hold_flag_o),
        .preempt_o   (preempt_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock: 10 ns period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 1: reset with all requests asserted
        rst_ni = 1'b0;
        req_i  = 4'hF;
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_valid", 32'(gnt_valid_o), 32'h0);
        chk("rst_idx", 32'(gnt_idx_o), 32'h0);
        chk("rst_hold", 32'(hold_flag_o), 32'h0);
        chk("rst_preempt", 32'(preempt_o), 32'h0);
        chk("rst_state", 32'(dbg_state_o), 32'(ARB_IDLE));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        chk("first_gnt", 32'(gnt_o), 32'h1);
        chk("first_valid", 32'(gnt_valid_o), 32'h1);
        chk("first_idx", 32'(gnt_idx_o), 32'h0);
        chk("first_hold", 32'(hold_flag_o), 32'h1);
        chk("first_state", 32'(dbg_state_o), 32'(ARB_OWNED));

        // 2: round-robin rotation, 4 cycles per owner, preempt on every change
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rr_gnt_%0d", k), 32'(gnt_o), 32'(1 << ((k / 4) % 4)));
            chk($sformatf("rr_idx_%0d", k), 32'(gnt_idx_o), 32'((k / 4) % 4));
            chk($sformatf("rr_pre_%0d", k), 32'(preempt_o), 32'((k % 4) == 0));
            chk($sformatf("rr_hold_%0d", k), 32'(hold_flag_o), 32'h1);
        end

        // 3: drop handover from m0 to m3
        req_i = 4'b0001;
        step();
        chk("ho_gnt0", 32'(gnt_o), 32'h1);
        chk("ho_hold0", 32'(hold_flag_o), 32'h0);
        req_i = 4'b1000;
        #1;
        chk("ho_hold_pre", 32'(hold_flag_o), 32'h0);
        step();
        chk("ho_gnt3", 32'(gnt_o), 32'h8);
        chk("ho_idx3", 32'(gnt_idx_o), 32'h3);
        chk("ho_pre", 32'(preempt_o), 32'h0);
        chk("ho_hold3", 32'(hold_flag_o), 32'h1);
        req_i = 4'b0000;
        #1;
        chk("ho_hold_rel", 32'(hold_flag_o), 32'h1);
        step();
        chk("idle_gnt", 32'(gnt_o), 32'h0);
        chk("idle_valid", 32'(gnt_valid_o), 32'h0);
        chk("idle_idx", 32'(gnt_idx_o), 32'h0);
        chk("idle_hold", 32'(hold_flag_o), 32'h0);
        chk("idle_state", 32'(dbg_state_o), 32'(ARB_IDLE));

        // 4: lone owner keeps the bus indefinitely
        req_i = 4'b0100;
        step();
        chk("lone_first", 32'(gnt_o), 32'h4);
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("lone_gnt_%0d", k), 32'(gnt_o), 32'h4);
            chk($sformatf("lone_pre_%0d", k), 32'(preempt_o), 32'h0);
            chk($sformatf("lone_hold_%0d", k), 32'(hold_flag_o), 32'h1);
        end

        // 5: owner m1 drops on its expiry cycle while m2 waits
        req_i = 4'b0010;
        step();
        chk("exp_gnt1", 32'(gnt_o), 32'h2);
        chk("exp_pre0", 32'(preempt_o), 32'h0);
        req_i = 4'b0110;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("exp_own_%0d", k), 32'(gnt_o), 32'h2);
            chk($sformatf("exp_hold_%0d", k), 32'(hold_flag_o), 32'h0);
        end
        req_i = 4'b0100;
        step();
        chk("exp_gnt2", 32'(gnt_o), 32'h4);
        chk("exp_pre", 32'(preempt_o), 32'h0);
        chk("exp_hold2", 32'(hold_flag_o), 32'h1);

        // 6: asynchronous reset between edges while m2 owns
        step();
        chk("ar_pre_gnt", 32'(gnt_o), 32'h4);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt_o), 32'h0);
        chk("ar_hold", 32'(hold_flag_o), 32'h0);
        chk("ar_idx", 32'(gnt_idx_o), 32'h0);
        chk("ar_state", 32'(dbg_state_o), 32'(ARB_IDLE));
        req_i = 4'b0110;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        chk("ar_gnt1", 32'(gnt_o), 32'h2);
        chk("ar_idx1", 32'(gnt_idx_o), 32'h1);
        chk("ar_pre", 32'(preempt_o), 32'h0);

        // Restart from pointer 0: with m1..m3 requesting after reset, m1 wins.
        rst_ni = 1'b0;
        req_i  = 4'b1110;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        chk("ar2_gnt1", 32'(gnt_o), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
